// File: rtl/dual_port_ram_sync.sv
// ---------------------------------------------------------------------------
// dual_port_ram_sync
//
// Single-clock, true dual-port synchronous RAM. This is a generic storage
// primitive, used for example for the ARP table, where each 80-bit entry
// holds an IPv4 address (32 bits) and a MAC address (48 bits).
//
// Both ports read every cycle with one cycle of latency. Reads return the
// old contents: a same-port write shows up on the next read, and a
// cross-port write to the same address in the same cycle is not visible.
// When both ports write the same address in the same cycle, port A wins.
//
// Optional feature (macro RAM_RST_CLEAR_EN):
//   When it is defined, rst starts a sweep that zeroes every entry, one
//   entry per cycle. init_busy is high during the sweep. While it is high,
//   both write enables are ignored and both read outputs are held at 0.
//   When it is undefined, reset leaves memory untouched and init_busy is
//   tied to 0.
//
// Parameters:
//   AW        address width, depth = 2**AW
//   DW        data width
//
// Ports:
//   clk       clock, shared by both ports
//   rst       synchronous, active-high reset
//   a_a       port A address
//   d_a       port A write data
//   w_a       port A write enable
//   q_a       port A registered read data
//   a_b       port B address
//   d_b       port B write data
//   w_b       port B write enable
//   q_b       port B registered read data
//   init_busy high while the reset clear sweep is running
// ---------------------------------------------------------------------------
module dual_port_ram_sync #(
  parameter int AW = 2,
  parameter int DW = 80
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a_a,
  input  logic [DW-1:0] d_a,
  input  logic          w_a,
  output logic [DW-1:0] q_a,
  input  logic [AW-1:0] a_b,
  input  logic [DW-1:0] d_b,
  input  logic          w_b,
  output logic [DW-1:0] q_b,
  output logic          init_busy
);

  localparam int DEPTH = 1 << AW;

  // Contents start all-zero from the declaration initialiser.
  logic [DW-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DW-1:0] q_a_q;
  logic [DW-1:0] q_b_q;

  // The clear sweep has two qualifiers:
  //   clr_active  the sweep owns the array this cycle
  //   clr_addr    the entry being zeroed
  logic          clr_active;
  logic [AW-1:0] clr_addr;

`ifdef RAM_RST_CLEAR_EN
  logic [AW-1:0] clr_cnt_q;
  logic [AW-1:0] clr_cnt_d;
  logic          busy_q = 1'b0;
  logic          busy_d;

  always_comb begin
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    if (rst) begin
      // A reset during a sweep restarts the sweep at entry 0.
      clr_cnt_d = '0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == {AW{1'b1}}) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    clr_cnt_q <= clr_cnt_d;
    busy_q    <= busy_d;
  end

  assign clr_active = busy_q;
  assign clr_addr   = clr_cnt_q;
  assign init_busy  = busy_q;
`else
  assign clr_active = 1'b0;
  assign clr_addr   = '0;
  assign init_busy  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // Outputs are cleared and any write on this edge is dropped.
      q_a_q <= '0;
      q_b_q <= '0;
    end else if (clr_active) begin
      q_a_q           <= '0;
      q_b_q           <= '0;
      mem_q[clr_addr] <= '0;
    end else begin
      // The nonblocking reads sample the pre-edge contents, which gives
      // read-first behaviour on both ports.
      q_a_q <= mem_q[a_a];
      q_b_q <= mem_q[a_b];
      // Port B writes first so that port A overrides it when both ports
      // write the same address.
      if (w_b) begin
        mem_q[a_b] <= d_b;
      end
      if (w_a) begin
        mem_q[a_a] <= d_a;
      end
    end
  end

  assign q_a = q_a_q;
  assign q_b = q_b_q;

endmodule

// File: tb/tb_dual_port_ram_sync.sv
module tb_dual_port_ram_sync;

  localparam int AW    = 2;
  localparam int DW    = 80;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] a_a;
  logic [DW-1:0] d_a;
  logic          w_a;
  logic [DW-1:0] q_a;
  logic [AW-1:0] a_b;
  logic [DW-1:0] d_b;
  logic          w_b;
  logic [DW-1:0] q_b;
  logic          init_busy;

  always #5 clk = ~clk;

  dual_port_ram_sync #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_a       (a_a),
    .d_a       (d_a),
    .w_a       (w_a),
    .q_a       (q_a),
    .a_b       (a_b),
    .d_b       (d_b),
    .w_b       (w_b),
    .q_b       (q_b),
    .init_busy (init_busy)
  );

  typedef struct {
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic          busy;
    string         tag;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model [DEPTH];
  int            sweep_left = 0;
  int            sweep_idx  = 0;
  int            checks     = 0;
  int            errors     = 0;
  int            txn        = 0;

  function automatic logic [DW-1:0] rnd80();
    logic [31:0] w0;
    logic [31:0] w1;
    logic [15:0] w2;
    w0 = $urandom();
    w1 = $urandom();
    w2 = 16'($urandom_range(0, 65535));
    return {w0, w1, w2};
  endfunction

  // Drive one cycle of stimulus and predict what the outputs show after the
  // next rising edge. The caller is at a falling edge.
  task automatic step(input logic r, input logic wa, input logic [AW-1:0] aa,
                      input logic [DW-1:0] da, input logic wb,
                      input logic [AW-1:0] ab, input logic [DW-1:0] db,
                      input string tag);
    exp_t e;
    rst = r; w_a = wa; a_a = aa; d_a = da; w_b = wb; a_b = ab; d_b = db;
    e.tag = tag;
    if (r) begin
      e.qa = '0;
      e.qb = '0;
`ifdef RAM_RST_CLEAR_EN
      sweep_left = DEPTH;
      sweep_idx  = 0;
`endif
    end else if (sweep_left > 0) begin
      e.qa = '0;
      e.qb = '0;
      model[sweep_idx] = '0;
      sweep_idx++;
      sweep_left--;
    end else begin
      e.qa = model[aa];
      e.qb = model[ab];
      if (wb) model[ab] = db;
      if (wa) model[aa] = da;  // port A wins on a collision
    end
    e.busy = (sweep_left > 0);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rd(input logic [AW-1:0] aa, input logic [AW-1:0] ab, input string tag);
    step(1'b0, 1'b0, aa, '0, 1'b0, ab, '0, tag);
  endtask

  // Monitor: one expected entry per clock, sampled just after the edge.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ok = 1'b1;
        checks++;
        if (q_a !== e.qa) begin
          errors++; ok = 1'b0;
          $display("FAIL %s q_a got %h expected %h", e.tag, q_a, e.qa);
        end
        checks++;
        if (q_b !== e.qb) begin
          errors++; ok = 1'b0;
          $display("FAIL %s q_b got %h expected %h", e.tag, q_b, e.qb);
        end
        checks++;
        if (init_busy !== e.busy) begin
          errors++; ok = 1'b0;
          $display("FAIL %s init_busy got %b expected %b", e.tag, init_busy, e.busy);
        end
        if (ok) $display("txn %0d %s q_a=%h q_b=%h busy=%b ok", txn, e.tag, q_a, q_b, init_busy);
        txn++;
      end
    end
  end

  initial begin
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst = 1'b1; w_a = 1'b0; w_b = 1'b0; a_a = '0; a_b = '0; d_a = '0; d_b = '0;
    @(negedge clk);

    step(1'b1, 1'b0, 0, '0, 1'b0, 0, '0, "reset0");
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, '0, "reset1");
    for (int i = 0; i < DEPTH + 1; i++) rd(2'(i), 2'(i), "post_reset_rd");

    // Port A write, port B reads it back one cycle later.
    step(1'b0, 1'b1, 2, 80'h0A000001_112233445566, 1'b0, 0, '0, "wr_a2");
    rd(0, 2, "rd_b2");
    rd(0, 2, "rd_b2_q");

    // Same-port read-during-write is read-first.
    x = rnd80(); y = rnd80();
    step(1'b0, 1'b1, 1, x, 1'b0, 0, '0, "wr_a1_x");
    step(1'b0, 1'b1, 1, y, 1'b0, 1, '0, "rdw_a1");
    rd(1, 1, "reread_a1");

    // Write collisions: the same address keeps A, different addresses keep both.
    step(1'b0, 1'b1, 3, 80'd5, 1'b1, 3, 80'd9, "coll_a3");
    rd(3, 3, "rd_coll3");
    step(1'b0, 1'b1, 0, 80'd5, 1'b1, 1, 80'd9, "wr_diff01");
    rd(0, 1, "rd_diff01");
    rd(1, 0, "rd_diff10");

    // Distinct words, then a port B scan that wraps back to entry 0.
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 2'(i), rnd80(), 1'b0, 0, '0, "fill");
    for (int i = 0; i <= DEPTH; i++) rd(0, 2'(i), "scan_b");
    rd(0, 0, "scan_tail");

    // Reset with non-zero outputs and a write pending on the same edge.
    rd(1, 2, "pre_rst");
    step(1'b1, 1'b1, 2, 80'hDEAD, 1'b1, 3, 80'hBEEF, "rst_wr");
    for (int i = 0; i < DEPTH + 2; i++) rd(2'(i), 2'(3 - (i % 4)), "after_rst");

    // Prefill, then reset followed by write attempts while any sweep runs.
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 2'(i), rnd80() | 80'd1, 1'b0, 0, '0, "prefill");
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, '0, "sweep_rst");
    for (int i = 0; i < DEPTH + 1; i++)
      step(1'b0, 1'b1, 2'(i), rnd80(), 1'b1, 2'(i + 1), rnd80(), "sweep_wr");
    for (int i = 0; i <= DEPTH; i++) rd(2'(i), 2'(i), "sweep_rd");

    // Random traffic with occasional resets.
    for (int n = 0; n < 250; n++)
      step(($urandom_range(0, 31) == 0), 1'($urandom()), 2'($urandom()), rnd80(),
           1'($urandom()), 2'($urandom()), rnd80(), "rand");
    for (int i = 0; i < DEPTH; i++) rd(2'(i), 2'(i), "final_rd");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_sync.md
Name: dual_port_ram_sync

Overview:
- Single-clock, true dual-port synchronous RAM used as a generic storage primitive, e.g. for the ARP table: 2^AW entries of 80 bits, each entry being IPv4 (32) and MAC (48).
- Two independent read/write ports A and B, each with address, write-data, write-enable and registered read-data.
- Port A typically does scan/update writes; port B typically does lookup scans.

Parameters:
- AW, default 2: address width; depth = 2^AW entries.
- DW, default 80: data width in bits.

Ports:
- clk, input, 1: clock; both ports are synchronous to it.
- rst, input, 1: synchronous, active-high reset.
- a_a, input, AW: port A address.
- d_a, input, DW: port A write data.
- w_a, input, 1: port A write enable.
- q_a, output, DW: port A registered read data.
- a_b, input, AW: port B address.
- d_b, input, DW: port B write data.
- w_b, input, 1: port B write enable.
- q_b, output, DW: port B registered read data.
- init_busy, output, 1: high while the reset clear sweep is running; tied 0 when RAM_RST_CLEAR_EN is undefined.

Behaviour:
- Storage: array of 2^AW words of DW bits. Without the optional clear, contents start all-zero via elaboration-time initialisation.
- Read latency is 1 cycle: q_x at edge N+1 equals mem[a_x sampled at edge N]. The read is performed every cycle regardless of w_x; there is no read enable.
- Write: if w_x is high at an edge, mem[a_x] <= d_x.
- Same-port read-during-write is read-first: q_x shows the old contents; the new data is visible on the next cycle's read.
- Cross-port read of an address written by the other port in the same cycle returns the old contents.
- Both ports writing the same address in the same cycle: port A wins, port B's write is discarded. Different addresses: both writes complete.
- Address arithmetic is the caller's concern. The RAM only indexes by a_x, which wraps naturally at 2^AW, and needs no bounds checking.
- Reset (rst=1 at an edge): q_a <= 0 and q_b <= 0. No write takes effect on that edge. Memory contents are retained unless RAM_RST_CLEAR_EN is defined.
- Reset mid-operation: any write presented on the same edge as rst is dropped. Reads resume on the first edge with rst=0, so q is valid one cycle later.
- No internal FSM when the optional feature is compiled out.

Optional Feature:
- Macro RAM_RST_CLEAR_EN.
- Defined:
  - rst loads an internal clear counter to 0 and sets init_busy=1.
  - Each following cycle with rst=0 writes 0 to mem[counter] and increments the counter.
  - After writing entry 2^AW-1, init_busy drops to 0. Total 2^AW cycles after rst deasserts.
  - While init_busy=1: w_a/w_b are ignored and q_a/q_b are held at 0.
  - Re-asserting rst mid-sweep restarts the sweep at address 0.
- Undefined: no counter exists, init_busy is constant 0, and reset does not touch memory.

Test Plan:
- Write A at a_a=2 with d_a=80'h0A000001_112233445566; next cycle read B at a_b=2 -> q_b = 80'h0A000001_112233445566 exactly 1 cycle after the address is presented.
- mem[1]=X; port A writes Y to addr 1 while reading addr 1 -> q_a=X that cycle; re-read addr 1 -> q_a=Y.
- Same cycle, w_a=1 with d_a=5 and w_b=1 with d_b=9, both at addr 3 -> subsequent read returns 5. Repeat at addr 0 and addr 1 -> both values stored.
- Sequential scan on port B, a_b incrementing 0,1,2,3,0 after writing distinct words -> q_b returns each word in order one cycle later, including the wrap back to entry 0.
- Assert rst for 1 cycle with q_a/q_b non-zero and w_a=1 -> q outputs are 0, that write is absent, and other contents are unchanged (macro off).
- With RAM_RST_CLEAR_EN and all entries pre-filled non-zero: pulse rst -> init_busy high for exactly 4 cycles (AW=2), writes during the sweep are ignored, all entries read 0 afterwards.
